sobel_window_filter: RTL and testbench

- Consumer end of the 3x3 line-buffer window interface: takes the 72-bit z8..z0 pixel matrix each clock and produces one edge-magnitude pixel per clock.
- Pipelined Sobel operator with saturation, optional binarisation and image-border suppression.
- Sideband timing (hcount, vcount, hsync, vsync, blank, valid) is delayed in lockstep, so output pixels stay aligned with the display/ZBT write path.

---
 rtl/sobel_window_filter.sv | 198 +++++++++++++++++++
 tb/tb_sobel_window_filter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_filter.sv
// Sobel edge-magnitude filter consuming a 3x3 pixel window, one pixel per clock.
// Latency: fixed 3 clocks from input edge to output, full throughput.
// Backpressure: none; the pipeline always advances, in_valid only tags samples.
module sobel_window_filter #(
    parameter int COLS = 640,
    parameter int ROWS = 480
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [71:0] matrix,
    input  logic        in_valid,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        blank_in,
    input  logic [7:0]  threshold,
    input  logic        binarize,
    output logic [7:0]  pixel_out,
    output logic        out_valid,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        blank_out
);

    // Last active column/row; anything at or beyond counts as border,
    // which also covers the blanking region past the active area.
    localparam logic [10:0] H_LAST = 11'(COLS - 1);
    localparam logic [9:0]  V_LAST = 10'(ROWS - 1);

    // Sideband carried alongside the data through stages 1 and 2.
    typedef struct packed {
        logic        vld;
        logic [10:0] hcount;
        logic [9:0]  vcount;
        logic        hsync;
        logic        vsync;
        logic        blank;
        logic        border;
    } side_t;

    // Blank is held high out of reset so the display path sees blanking.
    localparam side_t SIDE_RST = '{
        vld: 1'b0, hcount: 11'd0, vcount: 10'd0,
        hsync: 1'b0, vsync: 1'b0, blank: 1'b1, border: 1'b0
    };

    // ------------------------------------------------------------------
    // Window unpack: rows are z8 z7 z6 / z5 z4 z3 / z2 z1 z0.
    // The centre pixel z4 does not contribute to either Sobel kernel.
    // ------------------------------------------------------------------
    logic [7:0] z8, z7, z6, z5, z3, z2, z1, z0;

    assign z8 = matrix[71:64];
    assign z7 = matrix[63:56];
    assign z6 = matrix[55:48];
    assign z5 = matrix[47:40];
    assign z3 = matrix[31:24];
    assign z2 = matrix[23:16];
    assign z1 = matrix[15:8];
    assign z0 = matrix[7:0];

    // ------------------------------------------------------------------
    // Stage 1: positive/negative kernel halves, border flag, controls.
    // ------------------------------------------------------------------
    logic [9:0] px_d, nx_d, py_d, ny_d;
    logic [9:0] px_q, nx_q, py_q, ny_q;
    side_t      s1_d, s1_q;
    logic [7:0] thr1_q;
    logic       bin1_q;

    // Kernel halves kept unsigned; the subtraction happens next stage.
    always_comb begin
        px_d = {2'b00, z8} + {1'b0, z5, 1'b0} + {2'b00, z2};
        nx_d = {2'b00, z6} + {1'b0, z3, 1'b0} + {2'b00, z0};
        py_d = {2'b00, z8} + {1'b0, z7, 1'b0} + {2'b00, z6};
        ny_d = {2'b00, z2} + {1'b0, z1, 1'b0} + {2'b00, z0};

        s1_d        = SIDE_RST;
        s1_d.vld    = in_valid;
        s1_d.hcount = hcount_in;
        s1_d.vcount = vcount_in;
        s1_d.hsync  = hsync_in;
        s1_d.vsync  = vsync_in;
        s1_d.blank  = blank_in;
        s1_d.border = (hcount_in == 11'd0) || (hcount_in >= H_LAST) ||
                      (vcount_in == 10'd0) || (vcount_in >= V_LAST);
    end

    // Stage 1 registers; threshold/binarize sampled here so they stay
    // aligned with the window they apply to.
    always_ff @(posedge clock) begin
        if (reset) begin
            px_q   <= '0;
            nx_q   <= '0;
            py_q   <= '0;
            ny_q   <= '0;
            s1_q   <= SIDE_RST;
            thr1_q <= '0;
            bin1_q <= 1'b0;
        end else begin
            px_q   <= px_d;
            nx_q   <= nx_d;
            py_q   <= py_d;
            ny_q   <= ny_d;
            s1_q   <= s1_d;
            thr1_q <= threshold;
            bin1_q <= binarize;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: signed gradients, absolute values, L1 magnitude.
    // ------------------------------------------------------------------
    logic signed [10:0] gx, gy;
    logic [9:0]         ax, ay;
    logic [10:0]        mag_d, mag_q;
    side_t              s2_q;
    logic [7:0]         thr2_q;
    logic               bin2_q;

    // |gx|,|gy| never exceed 1020, so the negation fits in 10 bits.
    always_comb begin
        gx    = $signed({1'b0, px_q}) - $signed({1'b0, nx_q});
        gy    = $signed({1'b0, py_q}) - $signed({1'b0, ny_q});
        ax    = gx[10] ? 10'(-gx) : gx[9:0];
        ay    = gy[10] ? 10'(-gy) : gy[9:0];
        mag_d = {1'b0, ax} + {1'b0, ay};
    end

    // Stage 2 registers: magnitude plus the sideband shifted along.
    always_ff @(posedge clock) begin
        if (reset) begin
            mag_q  <= '0;
            s2_q   <= SIDE_RST;
            thr2_q <= '0;
            bin2_q <= 1'b0;
        end else begin
            mag_q  <= mag_d;
            s2_q   <= s1_q;
            thr2_q <= thr1_q;
            bin2_q <= bin1_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: saturate, binarise, suppress border, register outputs.
    // ------------------------------------------------------------------
    logic [7:0]  sat;
    logic [7:0]  pix_d, pix_q;
    logic        vld3_q;
    logic [10:0] hcount3_q;
    logic [9:0]  vcount3_q;
    logic        hsync3_q, vsync3_q, blank3_q;

    // Border wins over binarisation; blanking-region pixels land here too.
    always_comb begin
        sat   = (mag_q > 11'd255) ? 8'hFF : mag_q[7:0];
        pix_d = sat;
        if (s2_q.border) begin
            pix_d = 8'h00;
        end else if (bin2_q) begin
            pix_d = (sat >= thr2_q) ? 8'hFF : 8'h00;
        end
    end

    // Output registers; no input reaches an output without three flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_q     <= '0;
            vld3_q    <= 1'b0;
            hcount3_q <= '0;
            vcount3_q <= '0;
            hsync3_q  <= 1'b0;
            vsync3_q  <= 1'b0;
            blank3_q  <= 1'b1;
        end else begin
            pix_q     <= pix_d;
            vld3_q    <= s2_q.vld;
            hcount3_q <= s2_q.hcount;
            vcount3_q <= s2_q.vcount;
            hsync3_q  <= s2_q.hsync;
            vsync3_q  <= s2_q.vsync;
            blank3_q  <= s2_q.blank;
        end
    end

    assign pixel_out  = pix_q;
    assign out_valid  = vld3_q;
    assign hcount_out = hcount3_q;
    assign vcount_out = vcount3_q;
    assign hsync_out  = hsync3_q;
    assign vsync_out  = vsync3_q;
    assign blank_out  = blank3_q;

endmodule

// File: tb/tb_sobel_window_filter.sv
// Scoreboard bench for sobel_window_filter: the driver queues the expected
// output with the cycle it is due, a monitor compares every due cycle.
module tb_sobel_window_filter;

    localparam int COLS = 640;
    localparam int ROWS = 480;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [71:0] matrix = '0;
    logic        in_valid = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        blank_in = 1'b1;
    logic [7:0]  threshold = '0;
    logic        binarize = 1'b0;
    logic [7:0]  pixel_out;
    logic        out_valid;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        hsync_out, vsync_out, blank_out;

    sobel_window_filter #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clock      (clock),
        .reset      (reset),
        .matrix     (matrix),
        .in_valid   (in_valid),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .blank_in   (blank_in),
        .threshold  (threshold),
        .binarize   (binarize),
        .pixel_out  (pixel_out),
        .out_valid  (out_valid),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .blank_out  (blank_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        logic [7:0]  pix;
        logic        vld;
        logic [10:0] hc;
        logic [9:0]  vc;
        logic        hs;
        logic        vs;
        logic        bl;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, req);
        end
    endtask

    function automatic logic [71:0] mk(input logic [7:0] z8, z7, z6, z5, z4, z3, z2, z1, z0);
        return {z8, z7, z6, z5, z4, z3, z2, z1, z0};
    endfunction

    // Reference Sobel with plain integer arithmetic.
    function automatic logic [7:0] model(input logic [71:0] m, input int hc, input int vc,
                                         input int thr, input logic bin);
        int z[9];
        int gx, gy, mag, sat;
        for (int k = 0; k < 9; k++) z[k] = int'(m[8*k +: 8]);
        gx  = (z[8] + 2*z[5] + z[2]) - (z[6] + 2*z[3] + z[0]);
        gy  = (z[8] + 2*z[7] + z[6]) - (z[2] + 2*z[1] + z[0]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        sat = (mag > 255) ? 255 : mag;
        if (hc == 0 || hc >= COLS - 1 || vc == 0 || vc >= ROWS - 1) return 8'd0;
        if (bin) return (sat >= thr) ? 8'd255 : 8'd0;
        return 8'(sat);
    endfunction

    // One input cycle; the result is due three edges later.
    task automatic drive(input logic [71:0] m, input logic v, input int hc, input int vc,
                         input logic hs, input logic vs, input logic bl,
                         input int thr, input logic bin, input logic [7:0] exp_pix);
        exp_t e;
        @(negedge clock);
        #1;
        reset     = 1'b0;
        matrix    = m;
        in_valid  = v;
        hcount_in = 11'(hc);
        vcount_in = 10'(vc);
        hsync_in  = hs;
        vsync_in  = vs;
        blank_in  = bl;
        threshold = 8'(thr);
        binarize  = bin;
        e = '{due: cyc + 3, pix: exp_pix, vld: v, hc: 11'(hc), vc: 10'(vc),
              hs: hs, vs: vs, bl: bl};
        sb.push_back(e);
    endtask

    task automatic idle();
        drive(72'd0, 1'b0, COLS + 10, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'd0);
    endtask

    // One reset cycle: in-flight results are dropped, reset values expected
    // for the next three cycles (overwritten if reset is held longer).
    task automatic do_reset();
        exp_t keep[$];
        exp_t e;
        @(negedge clock);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        matrix   = mk(8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9);
        foreach (sb[i]) if (sb[i].due <= cyc) keep.push_back(sb[i]);
        sb = keep;
        for (int k = 1; k <= 3; k++) begin
            e = '{due: cyc + k, pix: 8'd0, vld: 1'b0, hc: 11'd0, vc: 10'd0,
                  hs: 1'b0, vs: 1'b0, bl: 1'b1};
            sb.push_back(e);
        end
    endtask

    // Monitor: compare every expectation on the cycle it falls due.
    always @(negedge clock) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) begin
                chk("missed_slot", 32'(cyc), 32'(e.due));
            end else begin
                chk("pixel_out",  32'(pixel_out),  32'(e.pix));
                chk("out_valid",  32'(out_valid),  32'(e.vld));
                chk("hcount_out", 32'(hcount_out), 32'(e.hc));
                chk("vcount_out", 32'(vcount_out), 32'(e.vc));
                chk("sync_blank", 32'({hsync_out, vsync_out, blank_out}),
                    32'({e.hs, e.vs, e.bl}));
            end
        end
    end

    initial begin
        logic [71:0] flat, v200, v20, m;
        logic        v, hs, vs, bl, bin;
        int          thr;

        flat = mk(8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100);
        v200 = mk(8'd200, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0, 8'd200, 8'd0, 8'd0);
        v20  = mk(8'd20,  8'd0, 8'd0, 8'd20,  8'd0, 8'd0, 8'd20,  8'd0, 8'd0);

        do_reset();
        do_reset();

        // Flat window, vertical edges, saturation.
        drive(flat, 1'b1, 5, 5, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'd0);
        drive(v200, 1'b1, 10, 10, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'd255);
        drive(v20,  1'b1, 10, 10, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'd80);

        // Binarisation at the threshold boundary, then toggling per cycle.
        drive(v20, 1'b1, 11, 10, 1'b0, 1'b0, 1'b0, 80, 1'b1, 8'd255);
        drive(v20, 1'b1, 12, 10, 1'b0, 1'b0, 1'b0, 81, 1'b1, 8'd0);
        for (int k = 0; k < 6; k++)
            drive(v20, 1'b1, 13 + k, 10, 1'b0, 1'b0, 1'b0, (k % 2 == 1) ? 81 : 80, 1'b1,
                  (k % 2 == 1) ? 8'd0 : 8'd255);
        drive(flat, 1'b1, 20, 20, 1'b0, 1'b0, 1'b0, 0, 1'b1, 8'd255);

        // Borders, including the blanking region and binarise with thr 0.
        drive(v200, 1'b1, 0,        10,       1'b1, 1'b0, 1'b0, 0, 1'b0, 8'd0);
        drive(v200, 1'b1, COLS - 1, 10,       1'b0, 1'b1, 1'b0, 0, 1'b0, 8'd0);
        drive(v200, 1'b1, 10,       ROWS - 1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'd0);
        drive(v200, 1'b1, COLS + 5, 10,       1'b1, 1'b1, 1'b1, 0, 1'b0, 8'd0);
        drive(v200, 1'b1, 10,       0,        1'b0, 1'b0, 1'b0, 0, 1'b1, 8'd0);
        drive(v200, 1'b1, COLS - 2, ROWS - 2, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'd255);
        idle();
        idle();

        // Streaming with random windows, valid pattern and sideband.
        for (int i = 1; i <= 16; i++) begin
            m[31:0]  = $urandom();
            m[63:32] = $urandom();
            m[71:64] = 8'($urandom());
            v   = 1'($urandom_range(0, 1));
            hs  = 1'($urandom_range(0, 1));
            vs  = 1'($urandom_range(0, 1));
            bl  = 1'($urandom_range(0, 1));
            bin = (i > 10);
            thr = $urandom_range(0, 255);
            drive(m, v, i, 7, hs, vs, bl, thr, bin, model(m, i, 7, thr, bin));
        end

        // Reset with pixels in flight; nothing stale may emerge.
        drive(v20, 1'b1, 30, 30, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'd80);
        drive(v20, 1'b1, 31, 30, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'd80);
        drive(v20, 1'b1, 32, 30, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'd80);
        do_reset();
        drive(v200, 1'b1, 40, 30, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'd255);
        drive(v20,  1'b1, 41, 30, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'd80);
        idle();
        idle();

        // Drain: every queued expectation must have been consumed.
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clock);
        chk("drain_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
